// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_fsubtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin with borrow out.
module fsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d_out,
  output logic b_out
);

  assign d_out = a ^ b ^ bin;
  assign b_out = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf_out.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             bor_reg;
  logic [CW-1:0]    count_reg;
  logic             d_bit;
  logic             bor_next;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out of the datapath, so keep them aside.
  logic a_msb_reg;
  logic b_msb_reg;
`endif

  fsubtractor u_fsub (
    .a     (a_reg[0]),
    .b     (b_reg[0]),
    .bin   (bor_reg),
    .d_out (d_bit),
    .b_out (bor_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      bor_reg    <= 1'b0;
      count_reg  <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_out    <= 1'b0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            bor_reg   <= 1'b0;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_reg <= a_in[WIDTH-1];
            b_msb_reg <= b_in[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          res_reg   <= {d_bit, res_reg[WIDTH-1:1]};
          bor_reg   <= bor_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_BIT) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          done       <= 1'b1;
          diff_out   <= res_reg;
          borrow_out <= bor_reg;
          busy       <= 1'b0;
          state_reg  <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_out    <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ res_reg[WIDTH-1]);
`endif
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): a driver pushes expected
// results computed arithmetically, a negedge monitor pops them on each done.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff_out;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf_out;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf_out    (ovf_out)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int done_cyc);
    exp_t e;
    int   d;
    int   s;
    d = int'(a) - int'(b);
    s = int'($signed(a)) - int'($signed(b));
    e.diff   = W'(d);
    e.borrow = (d < 0);
    e.ovf    = (s > 127) || (s < -128);
    e.cyc    = done_cyc;
    return e;
  endfunction

  // Called just after a clock edge: start is sampled on the next edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sb.push_back(model(a, b, cyc + W + 2));
    $display("op a=0x%02h b=0x%02h", a, b);
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    repeat (W + 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      check("done_pulse_width", int'(prev_done), 0);
      if (sb.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done diff=0x%02h borrow=%0d cycle=%0d", diff_out, borrow_out, cyc);
        check("diff", int'(diff_out), int'(e.diff));
        check("borrow", int'(borrow_out), int'(e.borrow));
        check("latency", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf_out), int'(e.ovf));
`endif
      end
    end
    prev_done = done;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff_out), 0);
    check("rst_borrow", int'(borrow_out), 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", int'(ovf_out), 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases, including wrap-around and equal operands.
    do_op(8'h35, 8'h12);
    do_op(8'h10, 8'h20);
    do_op(8'h00, 8'h01);
    do_op(8'h5A, 8'h5A);
    do_op(8'h80, 8'h01);
    do_op(8'h7F, 8'hFF);
    do_op(8'hFF, 8'h00);
    drain();

    // start held high: a new pair is taken only every W+2 cycles.
    start = 1'b1;
    for (int op = 0; op < 4; op++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      sb.push_back(model(a_in, b_in, cyc + W + 2));
      $display("held op a=0x%02h b=0x%02h", a_in, b_in);
      repeat (W + 2) begin
        @(posedge clk); #1;
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
    end
    start = 1'b0;
    drain();

    // Reset in the middle of SHIFT after four bits.
    start = 1'b1;
    a_in  = 8'hC3;
    b_in  = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("mid_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("reset mid-op busy=%0d done=%0d diff=0x%02h", busy, done, diff_out);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff_out), 0);
    check("abort_borrow", int'(borrow_out), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_op(8'h07, 8'h03);
    drain();

    // Randomized traffic with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
